bram_fifo_ctrl: RTL and testbench

- Byte-stream FIFO controller that sits directly upstream of bram_512x8 and drives its raddr/waddr/wdata/wren ports.
- Turns the RAM into a first-word-fall-through valid/ready FIFO.
- Hides the RAM's one-cycle registered read latency behind a 2-entry output buffer, sustaining 1 push + 1 pop per clock.
- Used as the standard buffering stage in front of byte consumers (UART TX, debug streams).

---
 rtl/bram_fifo_ctrl.sv | 102 ++++++++++
 tb/tb_bram_fifo_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/bram_fifo_ctrl.sv
// First-word-fall-through byte FIFO built on an external registered-read RAM.
// A 2-entry output buffer hides the one-cycle RAM read latency so one push
// and one pop can both happen every clock.
module bram_fifo_ctrl #(
  parameter int WIDTH = 8,
  parameter int AW    = 9
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [AW:0]      count,
  output logic [AW-1:0]    ram_raddr,
  input  logic [WIDTH-1:0] ram_rdata,
  output logic [AW-1:0]    ram_waddr,
  output logic [WIDTH-1:0] ram_wdata,
  output logic             ram_wren
);

  localparam logic [AW:0] FULL = {1'b1, {AW{1'b0}}};

  logic [AW:0]             wptr_q, wptr_d, rptr_q, rptr_d, count_q, count_d;
  logic [AW:0]             ram_cnt;
  logic [AW-1:0]           raddr_q;
  logic                    inflight_q, inflight_d;
  logic                    armed_q;
  logic [1:0][WIDTH-1:0]   buf_q, buf_d;
  logic [1:0]              bcnt_q, bcnt_d;
  logic [2:0]              occ;
  logic                    push, pop, issue;

  // Handshakes, RAM port drive and read-issue decision.
  always_comb begin
    in_ready  = armed_q && (count_q != FULL);
    out_valid = (bcnt_q != 2'd0);
    out_data  = buf_q[0];
    count     = count_q;
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
    // Only registered pointers: a word written this cycle is never read now.
    ram_cnt   = wptr_q - rptr_q;
    // Buffer occupancy after this edge if nothing new is issued.
    occ       = {1'b0, bcnt_q} + {2'b00, inflight_q} - {2'b00, pop};
    issue     = (ram_cnt != '0) && (occ < 3'd2);
    ram_raddr = issue ? rptr_q[AW-1:0] : raddr_q;
    ram_wren  = push;
    ram_waddr = wptr_q[AW-1:0];
    ram_wdata = push ? in_data : '0;
  end

  // Next-state for pointers, occupancy count and the output buffer.
  always_comb begin
    wptr_d     = wptr_q + {{AW{1'b0}}, push};
    rptr_d     = rptr_q + {{AW{1'b0}}, issue};
    inflight_d = issue;
    count_d    = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
    buf_d  = buf_q;
    bcnt_d = bcnt_q;
    if (pop) begin
      buf_d[0] = buf_q[1];
      bcnt_d   = bcnt_q - 2'd1;
    end
    // Occupancy is at most 1 here, so bit 0 selects the free slot.
    if (inflight_q) begin
      buf_d[bcnt_d[0]] = ram_rdata;
      bcnt_d           = bcnt_d + 2'd1;
    end
  end

  // State registers; reset also drops any read still in flight.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      raddr_q    <= '0;
      inflight_q <= 1'b0;
      armed_q    <= 1'b0;
      buf_q      <= '0;
      bcnt_q     <= 2'd0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      raddr_q    <= ram_raddr;
      inflight_q <= inflight_d;
      armed_q    <= 1'b1;
      buf_q      <= buf_d;
      bcnt_q     <= bcnt_d;
    end
  end

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Scoreboard bench for bram_fifo_ctrl with a behavioural 512x8 RAM.
module tb_bram_fifo_ctrl;
  localparam int WIDTH = 8;
  localparam int AW    = 9;
  localparam int DEPTH = 1 << AW;

  logic             clock = 1'b0;
  logic             rst_n = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [AW:0]      count;
  logic [AW-1:0]    ram_raddr, ram_waddr;
  logic [WIDTH-1:0] ram_rdata = '0, ram_wdata;
  logic             ram_wren;

  bram_fifo_ctrl #(.WIDTH(WIDTH), .AW(AW)) dut (
    .clock(clock), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .count(count),
    .ram_raddr(ram_raddr), .ram_rdata(ram_rdata),
    .ram_waddr(ram_waddr), .ram_wdata(ram_wdata), .ram_wren(ram_wren)
  );

  always #5 clock = ~clock;

  // Registered-read RAM model.
  logic [WIDTH-1:0] mem [DEPTH];
  always @(posedge clock) begin
    if (ram_wren) mem[ram_waddr] <= ram_wdata;
    ram_rdata <= mem[ram_raddr];
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model state: ordered contents and occupancy.
  logic [WIDTH-1:0] sbq[$];
  int               mcnt = 0;
  logic             armed;
  logic             lim3 = 1'b0;
  logic             stall_prev = 1'b0;
  logic [WIDTH-1:0] stall_data = '0;

  always @(posedge clock or negedge rst_n)
    if (!rst_n) armed <= 1'b0;
    else        armed <= 1'b1;

  // Monitor: compares against the model and advances it on handshakes.
  always @(negedge clock) begin
    if (!rst_n) begin
      sbq.delete();
      mcnt = 0;
      stall_prev = 1'b0;
    end else begin
      chk("count", 32'(count), 32'(mcnt));
      chk("in_ready", 32'(in_ready), 32'(armed && (mcnt != DEPTH)));
      if (out_valid) chk("model_has_data", 32'(sbq.size() > 0), 32'd1);
      if (stall_prev) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_data", 32'(out_data), 32'(stall_data));
      end
      if (lim3) chk("count_le3", 32'(count <= 3), 32'd1);
      if (out_valid && out_ready && sbq.size() > 0)
        chk("pop_data", 32'(out_data), 32'(sbq.pop_front()));
      if (in_valid && in_ready) sbq.push_back(in_data);
      if (in_valid && in_ready) mcnt++;
      if (out_valid && out_ready) mcnt--;
      stall_prev = out_valid && !out_ready;
      stall_data = out_data;
    end
  end

  // Drive a stream of incrementing bytes; advances only on acceptance.
  task automatic stream(input int cycles, input logic [7:0] start,
                        input logic rnd_ready, input int bubble_from);
    logic [7:0] d;
    logic acc;
    d = start;
    in_valid = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      in_data = d;
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
      @(negedge clock);
      acc = in_ready;
      if (bubble_from >= 0 && i >= bubble_from) chk("no_bubble", 32'(out_valid), 32'd1);
      @(posedge clock); #1;
      if (acc) d = d + 8'd1;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    out_ready = 1'b1;
    n = 0;
    while (count != 0 && n < 2000) begin
      @(posedge clock); #1;
      n++;
    end
    chk("drain_done", 32'(count), 32'd0);
    repeat (3) @(posedge clock);
    #1;
  endtask

  initial begin
    int n;
    // Reset.
    rst_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_wren", 32'(ram_wren), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    rst_n = 1'b1;
    #1 chk("in_ready_before_edge", 32'(in_ready), 32'd0);
    @(posedge clock); #1;

    // Fill to full with out_ready low.
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      in_data = 8'(8'h46 + i);
      @(posedge clock); #1;
    end
    in_data = 8'h46;  // 513th push attempt
    chk("full_count", 32'(count), 32'(DEPTH));
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_out_valid", 32'(out_valid), 32'd1);
    chk("full_head", 32'(out_data), 32'h46);
    @(posedge clock); #1;
    in_valid = 1'b0;
    chk("full_no_overpush", 32'(count), 32'(DEPTH));

    // Drain one per clock.
    out_ready = 1'b1;
    repeat (DEPTH) @(posedge clock);
    #1;
    chk("drain_count", 32'(count), 32'd0);
    chk("drain_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b0;
    @(posedge clock); #1;

    // Single-push latency.
    in_data = 8'hA5; in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    chk("lat_k", 32'(out_valid), 32'd0);
    @(posedge clock); #1;
    chk("lat_k1", 32'(out_valid), 32'd0);
    @(posedge clock); #1;
    chk("lat_k2_valid", 32'(out_valid), 32'd1);
    chk("lat_k2_data", 32'(out_data), 32'hA5);
    drain();
    out_ready = 1'b0;

    // Continuous push+pop with pointer wrap.
    out_ready = 1'b1;
    lim3 = 1'b1;
    stream(1000, 8'h00, 1'b0, 4);
    repeat (6) @(posedge clock);
    #1;
    lim3 = 1'b0;
    chk("cont_empty", 32'(count), 32'd0);

    // Random backpressure.
    stream(600, 8'h80, 1'b1, -1);
    drain();

    // Reset mid-stream.
    out_ready = 1'b1;
    in_valid = 1'b1;
    stream(20, 8'h30, 1'b0, -1);
    in_valid = 1'b1;
    @(posedge clock); #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_wren", 32'(ram_wren), 32'd0);
    repeat (2) @(posedge clock);
    #1;
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clock); #1;
    in_data = 8'h11; in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 10) begin
      @(negedge clock);
      n++;
    end
    chk("post_rst_valid", 32'(out_valid), 32'd1);
    chk("post_rst_data", 32'(out_data), 32'h11);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
